// File: rtl/ibex_mem_arb_pkg.sv
// Shared types and helpers for the Ibex memory-port arbiter.
package ibex_mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ibex_mem_arb_fifo.sv
// In-order route FIFO: remembers which channel owns each outstanding transaction.
module ibex_mem_arb_fifo
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned PTR_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Arbitrates several Ibex req/gnt/rvalid channels onto one memory port and
// routes in-order responses back to the channel that issued each request.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 2,
  parameter arb_mode_e   ARB_MODE  = ARB_FIXED,
  localparam int unsigned BE_W     = DATA_W / 8,
  localparam int unsigned CH_W     = idx_width(NUM_CH),
  localparam int unsigned OUT_W    = $clog2(MAX_OUTST+1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  output logic [NUM_CH-1:0]        ch_gnt_o,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*BE_W-1:0]   ch_be_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]        ch_rvalid_o,
  output logic [NUM_CH-1:0]        ch_err_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [BE_W-1:0]          mem_be_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic                     mem_err_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic [OUT_W-1:0]         outst_o,
  output logic                     unexp_rsp_o
);

  logic [CH_W-1:0] arb_sel;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] lock_ch;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] head;
  logic            found;
  logic            locked;
  logic            fifo_full;
  logic            fifo_empty;
  logic            hs;
  logic            pop;

  always_comb begin
    arb_sel = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (ARB_MODE == ARB_RR) ? CH_W'((32'(rr_ptr) + i) % NUM_CH) : CH_W'(i);
      if (!found && ch_req_i[cand]) begin
        found   = 1'b1;
        arb_sel = cand;
      end
    end
  end

  // A stalled request keeps its channel so the memory side sees stable
  // address/data until it grants; the lock yields only if that channel lets go.
  assign sel = (locked && ch_req_i[lock_ch]) ? lock_ch : arb_sel;

  assign mem_req_o   = (|ch_req_i) & ~fifo_full & ~rst_i;
  assign hs          = mem_req_o & mem_gnt_i;
  assign pop         = mem_rvalid_i & ~fifo_empty & ~rst_i;

  assign mem_we_o    = ch_we_i[sel];
  assign mem_be_o    = BE_W'(ch_be_i >> (32'(sel) * BE_W));
  assign mem_addr_o  = ADDR_W'(ch_addr_i >> (32'(sel) * ADDR_W));
  assign mem_wdata_o = DATA_W'(ch_wdata_i >> (32'(sel) * DATA_W));
  assign ch_rdata_o  = mem_rdata_i;

  always_comb begin
    ch_gnt_o    = '0;
    ch_rvalid_o = '0;
    ch_err_o    = '0;
    if (hs) begin
      ch_gnt_o[sel] = 1'b1;
    end
    if (pop) begin
      ch_rvalid_o[head] = 1'b1;
      ch_err_o[head]    = mem_err_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked      <= 1'b0;
      lock_ch     <= '0;
      rr_ptr      <= '0;
      unexp_rsp_o <= 1'b0;
    end else begin
      locked  <= mem_req_o & ~mem_gnt_i;
      lock_ch <= sel;
      if (hs && (ARB_MODE == ARB_RR)) begin
        rr_ptr <= (32'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
      end
      if (mem_rvalid_i && fifo_empty) begin
        unexp_rsp_o <= 1'b1;
      end
    end
  end

  ibex_mem_arb_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (CH_W)
  ) u_route_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (hs),
    .push_data (sel),
    .pop       (pop),
    .pop_data  (head),
    .count     (outst_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: a fixed-priority and a round-robin instance share
// stimulus; an outstanding-list model checks both every cycle.
module tb_ibex_mem_arbiter;
  import ibex_mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [11:0] be;
  logic [95:0] addr;
  logic [95:0] wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic        mem_err;
  logic [31:0] mem_rdata;

  logic [2:0]  gnt_o    [2];
  logic [2:0]  rvalid_o [2];
  logic [2:0]  err_o    [2];
  logic [31:0] rdata_o  [2];
  logic        mreq_o   [2];
  logic        mwe_o    [2];
  logic [3:0]  mbe_o    [2];
  logic [31:0] maddr_o  [2];
  logic [31:0] mwdata_o [2];
  logic [1:0]  outst_o  [2];
  logic        unexp_o  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_mem_arbiter #(
    .NUM_CH(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .ARB_MODE(ARB_FIXED)
  ) dut_fix (
    .clk_i(clk), .rst_i(rst), .ch_req_i(req), .ch_gnt_o(gnt_o[0]), .ch_we_i(we),
    .ch_be_i(be), .ch_addr_i(addr), .ch_wdata_i(wdata), .ch_rvalid_o(rvalid_o[0]),
    .ch_err_o(err_o[0]), .ch_rdata_o(rdata_o[0]), .mem_req_o(mreq_o[0]),
    .mem_we_o(mwe_o[0]), .mem_be_o(mbe_o[0]), .mem_addr_o(maddr_o[0]),
    .mem_wdata_o(mwdata_o[0]), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_err_i(mem_err), .mem_rdata_i(mem_rdata), .outst_o(outst_o[0]),
    .unexp_rsp_o(unexp_o[0])
  );

  ibex_mem_arbiter #(
    .NUM_CH(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .ARB_MODE(ARB_RR)
  ) dut_rr (
    .clk_i(clk), .rst_i(rst), .ch_req_i(req), .ch_gnt_o(gnt_o[1]), .ch_we_i(we),
    .ch_be_i(be), .ch_addr_i(addr), .ch_wdata_i(wdata), .ch_rvalid_o(rvalid_o[1]),
    .ch_err_o(err_o[1]), .ch_rdata_o(rdata_o[1]), .mem_req_o(mreq_o[1]),
    .mem_we_o(mwe_o[1]), .mem_be_o(mbe_o[1]), .mem_addr_o(maddr_o[1]),
    .mem_wdata_o(mwdata_o[1]), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_err_i(mem_err), .mem_rdata_i(mem_rdata), .outst_o(outst_o[1]),
    .unexp_rsp_o(unexp_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: list of channels awaiting responses, rotation pointer, stalled channel.
  int mq    [2][2];
  int mcnt  [2];
  int mptr  [2];
  int mlock [2];
  bit munexp[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  w;
      int  c;
      bit  ereq;
      logic [31:0] erv;
      string tag;
      tag = (d == 0) ? "fix" : "rr";
      if (rst) begin
        check({tag, " rst gnt"},    32'(gnt_o[d]), 0);
        check({tag, " rst rvalid"}, 32'(rvalid_o[d]), 0);
        check({tag, " rst err"},    32'(err_o[d]), 0);
        check({tag, " rst mreq"},   32'(mreq_o[d]), 0);
        check({tag, " rst outst"},  32'(outst_o[d]), 0);
        check({tag, " rst unexp"},  32'(unexp_o[d]), 0);
        mcnt[d] = 0; mptr[d] = 0; mlock[d] = -1; munexp[d] = 1'b0;
      end else begin
        ereq = (req != 3'b000) && (mcnt[d] < 2);
        w = -1;
        if (mlock[d] >= 0 && req[mlock[d]]) w = mlock[d];
        else begin
          for (int k = 0; k < 3; k++) begin
            c = (d == 1) ? (mptr[d] + k) % 3 : k;
            if (w < 0 && req[c]) w = c;
          end
        end
        check({tag, " mreq"}, 32'(mreq_o[d]), 32'(ereq));
        check({tag, " gnt"}, 32'(gnt_o[d]), (ereq && mem_gnt) ? 32'(1 << w) : 0);
        if (ereq) begin
          check({tag, " addr"},  maddr_o[d], addr[w*32 +: 32]);
          check({tag, " wdata"}, mwdata_o[d], wdata[w*32 +: 32]);
          check({tag, " be"},    32'(mbe_o[d]), 32'(be[w*4 +: 4]));
          check({tag, " we"},    32'(mwe_o[d]), 32'(we[w]));
        end
        erv = (mem_rvalid && mcnt[d] > 0) ? 32'(1 << mq[d][0]) : 0;
        check({tag, " rvalid"}, 32'(rvalid_o[d]), erv);
        check({tag, " err"},    32'(err_o[d]), mem_err ? erv : 0);
        check({tag, " rdata"},  rdata_o[d], mem_rdata);
        check({tag, " outst"},  32'(outst_o[d]), 32'(mcnt[d]));
        check({tag, " unexp"},  32'(unexp_o[d]), 32'(munexp[d]));
        if (mem_rvalid) begin
          if (mcnt[d] > 0) begin
            mq[d][0] = mq[d][1];
            mcnt[d]--;
          end else munexp[d] = 1'b1;
        end
        if (ereq && mem_gnt) begin
          mq[d][mcnt[d]] = w;
          mcnt[d]++;
          mptr[d] = (w + 1) % 3;
        end
        mlock[d] = (ereq && !mem_gnt) ? w : -1;
      end
    end
  end

  task automatic step(input logic [2:0] r, input logic g, input logic rv, input logic e);
    @(posedge clk); #1;
    req = r; mem_gnt = g; mem_rvalid = rv; mem_err = e;
    mem_rdata = mem_rdata + 32'h1111_1111;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [2:0] rr_seq [5];

  initial begin
    rst = 1'b1; req = 3'b111; we = 3'b010; be = {4'hC, 4'hF, 4'h3};
    addr  = {32'h0000_0200, 32'h0000_0100, 32'h0000_0040};
    wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_err = 1'b0; mem_rdata = '0;
    rr_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    @(negedge clk);
    check("reset mreq held low", 32'(mreq_o[0]), 0);
    check("reset outst", 32'(outst_o[1]), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);

    // Fixed priority
    step(3'b011, 1'b1, 1'b0, 1'b0);
    check("fixed both req", 32'(gnt_o[0]), 32'b001);
    step(3'b010, 1'b1, 1'b1, 1'b0);
    check("fixed ch1 after ch0 drop", 32'(gnt_o[0]), 32'b010);
    check("fixed first rsp to ch0", 32'(rvalid_o[0]), 32'b001);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    check("fixed second rsp to ch1", 32'(rvalid_o[0]), 32'b010);
    step(3'b000, 1'b0, 1'b0, 1'b0);

    // Round robin from reset
    pulse_rst();
    step(3'b111, 1'b1, 1'b0, 1'b0);
    check("rr grant 0", 32'(gnt_o[1]), 32'b001);
    for (int i = 0; i < 5; i++) begin
      step(3'b111, 1'b1, 1'b1, 1'b0);
      check($sformatf("rr grant %0d", i + 1), 32'(gnt_o[1]), 32'(rr_seq[i]));
      check("fixed stays ch0", 32'(gnt_o[0]), 32'b001);
    end
    step(3'b000, 1'b0, 1'b1, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    check("rr drained", 32'(outst_o[1]), 0);

    // Stall lock on ch1, then ch0 joins
    for (int i = 0; i < 3; i++) begin
      step(3'b010, 1'b0, 1'b0, 1'b0);
      check("stall addr", maddr_o[0], 32'h100);
    end
    for (int i = 0; i < 2; i++) begin
      step(3'b011, 1'b0, 1'b0, 1'b0);
      check("locked addr", maddr_o[0], 32'h100);
      check("locked no gnt", 32'(gnt_o[0]), 0);
    end
    step(3'b011, 1'b1, 1'b0, 1'b0);
    check("locked gnt ch1", 32'(gnt_o[0]), 32'b010);
    check("locked gnt addr", maddr_o[0], 32'h100);
    step(3'b001, 1'b1, 1'b0, 1'b0);
    check("then ch0 addr", maddr_o[0], 32'h40);

    // Full at two outstanding, ordered responses with error
    step(3'b011, 1'b1, 1'b0, 1'b0);
    check("full outst", 32'(outst_o[0]), 2);
    check("full mreq low", 32'(mreq_o[0]), 0);
    check("full no gnt", 32'(gnt_o[0]), 0);
    step(3'b001, 1'b1, 1'b1, 1'b1);
    check("rsp1 to ch1", 32'(rvalid_o[0]), 32'b010);
    check("rsp1 err ch1", 32'(err_o[0]), 32'b010);
    check("no bypass on pop", 32'(mreq_o[0]), 0);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    check("rsp2 to ch0", 32'(rvalid_o[0]), 32'b001);
    check("rsp2 no err", 32'(err_o[0]), 0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    check("empty again", 32'(outst_o[0]), 0);

    // Unexpected response, reset mid-transaction
    step(3'b000, 1'b0, 1'b1, 1'b0);
    check("unexp dropped", 32'(rvalid_o[0]), 0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    check("unexp set", 32'(unexp_o[0]), 1);
    step(3'b001, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    check("inflight outst", 32'(outst_o[0]), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst clears outst", 32'(outst_o[0]), 0);
    check("rst clears unexp", 32'(unexp_o[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    step(3'b000, 1'b0, 1'b1, 1'b0);
    check("late rsp dropped", 32'(rvalid_o[0]), 0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    check("late rsp flags", 32'(unexp_o[0]), 1);
    step(3'b000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
